// File: rtl/mul_seq_ctrl.sv
// Sequential radix-4 unsigned multiplier controller: one shared add/accumulate step
// retires two multiplier bits per cycle; operands and product use valid/ready handshakes.
module mul_seq_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    localparam int unsigned STEPS = W / 2;
    localparam int unsigned KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [W-1:0]    mcand, mplier;
    logic [2*W-1:0]  acc, acc_step;
    logic [KW-1:0]   k;
    logic [W-1:0]    mplier_sh;
    logic [1:0]      d;
    logic [W+1:0]    pp;
    logic            accept, k_last;

    assign accept = (state == IDLE) && in_valid;
    assign k_last = (k == KW'(STEPS - 1));

    // Radix-4 partial product for the current digit, scaled into place by 2k
    always_comb begin
        mplier_sh = mplier >> {k, 1'b0};
        d         = mplier_sh[1:0];
        pp        = '0;
        case (d)
            2'd0: pp = '0;
            2'd1: pp = {2'b00, mcand};
            2'd2: pp = {1'b0, mcand, 1'b0};
            2'd3: pp = {2'b00, mcand} + {1'b0, mcand, 1'b0};
            default: pp = '0;
        endcase
        acc_step = acc + ((2*W)'(pp) << {k, 1'b0});
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) state_nx = RUN;
                RUN:  if (k_last)   state_nx = DONE;
                DONE: if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            k      <= '0;
        end else if (clear) begin
            acc <= '0;
            k   <= '0;
        end else if (accept) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            k      <= '0;
        end else if (state == RUN) begin
            acc <= acc_step;
            k   <= k + KW'(1);
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign p         = acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized self-checking bench for mul_seq_ctrl (W=8) against plain a*b arithmetic
// and the accept/latency/handshake timing rules.
module tb_mul_seq_ctrl;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a, b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic           busy;

    int total = 0;
    int bad   = 0;

    mul_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) return;
            tick();
        end
        chk("wait_idle_timeout", 64'(in_ready), 64'd1);
    endtask

    // One full transaction; hold>0 keeps out_ready low for that many DONE cycles
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input int hold);
        logic [2*W-1:0] exp;
        exp = (2*W)'(ta) * (2*W)'(tbv);
        wait_idle();
        a = ta; b = tbv; in_valid = 1'b1; out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        chk("accept_busy", 64'(busy), 64'd1);
        chk("accept_in_ready", 64'(in_ready), 64'd0);
        for (int i = 1; i < int'(W / 2); i++) begin
            a = W'($urandom); b = W'($urandom);
            tick();
            chk("run_no_valid", 64'(out_valid), 64'd0);
        end
        tick();
        chk("done_valid", 64'(out_valid), 64'd1);
        chk("done_p", 64'(p), 64'(exp));
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom);
                tick();
                chk("bp_valid", 64'(out_valid), 64'd1);
                chk("bp_p", 64'(p), 64'(exp));
                chk("bp_in_ready", 64'(in_ready), 64'd0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        chk("hs_valid_drop", 64'(out_valid), 64'd0);
        chk("hs_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    logic [W-1:0] qa [0:59];
    logic [W-1:0] qb [0:59];

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_p", 64'(p), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        run_op(8'd13, 8'd11, 0);
        run_op(8'd255, 8'd255, 0);
        run_op(8'd0, 8'd200, 0);
        run_op(8'd1, 8'hAA, 0);

        run_op(8'd7, 8'd9, 10);
        tick();
        chk("bp_no_second", 64'(busy), 64'd0);

        for (int r = 0; r < 20; r++)
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));

        // Continuous in_valid: captures only on idle edges, every W/2+2 cycles
        wait_idle();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            qa[n] = W'($urandom); qb[n] = W'($urandom);
            a = qa[n]; b = qb[n];
            tick();
            chk("ign_valid", 64'(out_valid), 64'(n % 6 == 4));
            chk("ign_in_ready", 64'(in_ready), 64'(n % 6 == 5));
            if (n % 6 == 4)
                chk("ign_p", 64'(p), 64'((2*W)'(qa[n-4]) * (2*W)'(qb[n-4])));
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // Clear at RUN step k=2 with in_valid also high
        wait_idle();
        a = 8'd21; b = 8'd37; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        clear = 1'b1; in_valid = 1'b1; a = 8'd99; b = 8'd99;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_in_ready", 64'(in_ready), 64'd1);
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_p", 64'(p), 64'd0);
        tick();
        chk("clr_no_capture", 64'(busy), 64'd0);
        run_op(8'd3, 8'd5, 0);

        // Asynchronous reset mid-RUN
        wait_idle();
        a = 8'd77; b = 8'd88; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_run_busy", 64'(busy), 64'd0);
        chk("arst_run_in_ready", 64'(in_ready), 64'd1);
        chk("arst_run_p", 64'(p), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-DONE
        a = 8'd55; b = 8'd66; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < int'(W / 2); i++) tick();
        chk("pre_arst_done", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_done_valid", 64'(out_valid), 64'd0);
        chk("arst_done_busy", 64'(busy), 64'd0);
        chk("arst_done_p", 64'(p), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        run_op(8'd100, 8'd100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
